// File: rtl/parameters_pkg.sv
// Curve25519 field constants and Montgomery multiplier geometry.
// Montgomery radix is R = 2^(MUL_DIGITS*MUL_DIGIT_W) = 2^256, so MONT_ONE = 2^256 mod p = 38.
package parameters_pkg;

  localparam int DATA_WIDTH  = 255;
  localparam int MUL_DIGIT_W = 64;
  localparam int MUL_DIGITS  = 4;

  localparam logic [DATA_WIDTH-1:0] MODULUS  = {{(DATA_WIDTH-8){1'b1}}, 8'hED};
  localparam logic [DATA_WIDTH-1:0] INV_EXP  = {{(DATA_WIDTH-8){1'b1}}, 8'hEB};
  localparam logic [DATA_WIDTH-1:0] MONT_ONE = DATA_WIDTH'(38);

endpackage

// File: rtl/point_to_affine_if.sv
// Request/result bundle between a point producer and point_to_affine.
// Start is a one-cycle pulse accepted only when idle; results are held after done.
interface point_to_affine_if;
  import parameters_pkg::*;

  logic                  start;
  logic [DATA_WIDTH-1:0] X;
  logic [DATA_WIDTH-1:0] Y;
  logic [DATA_WIDTH-1:0] Z;
  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] y;
  logic                  z_zero;
  logic                  busy;
  logic                  done;

  modport master (output start, X, Y, Z, input x, y, z_zero, busy, done);
  modport slave  (input start, X, Y, Z, output x, y, z_zero, busy, done);

endinterface

// File: rtl/mul_mont.sv
// Montgomery product a*b*2^-256 mod p, MUL_DIGIT_W radix-2 steps per cycle; operands captured on i_start.
// Latency MUL_DIGITS+2 cycles from i_start to the o_done pulse; o_res holds until the next start.
module mul_mont
  import parameters_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_res
);

  localparam int TW = DATA_WIDTH + 2;
  localparam int AW = MUL_DIGITS * MUL_DIGIT_W;
  localparam int CW = $clog2(MUL_DIGITS);
  localparam logic [TW-1:0] MOD_EXT = TW'(MODULUS);

  logic [AW-1:0]         r_a;
  logic [TW-1:0]         r_b;
  logic [TW-1:0]         r_t;
  logic [CW-1:0]         r_cnt;
  logic                  r_run;
  logic                  r_fin;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_res;
  logic [TW-1:0]         w_t_next;
  logic [DATA_WIDTH-1:0] w_red;

  // T stays below 2p between steps, so TW bits cover the 4p transient.
  always_comb begin
    w_t_next = r_t;
    for (int k = 0; k < MUL_DIGIT_W; k++) begin
      if (r_a[k])
        w_t_next = w_t_next + r_b;
      if (w_t_next[0])
        w_t_next = w_t_next + MOD_EXT;
      w_t_next = w_t_next >> 1;
    end
  end

  assign w_red = (r_t >= MOD_EXT) ? DATA_WIDTH'(r_t - MOD_EXT) : DATA_WIDTH'(r_t);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_t    <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_fin  <= 1'b0;
      r_done <= 1'b0;
      r_res  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_a   <= AW'(i_a);
        r_b   <= TW'(i_b);
        r_t   <= '0;
        r_cnt <= CW'(MUL_DIGITS - 1);
        r_run <= 1'b1;
        r_fin <= 1'b0;
      end else if (r_run) begin
        r_t <= w_t_next;
        r_a <= r_a >> MUL_DIGIT_W;
        if (r_cnt == '0) begin
          r_run <= 1'b0;
          r_fin <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end else if (r_fin) begin
        r_res  <= w_red;
        r_done <= 1'b1;
        r_fin  <= 1'b0;
      end
    end
  end

  assign o_done = r_done;
  assign o_res  = r_res;

endmodule

// File: rtl/point_to_affine.sv
// Projective-to-affine conversion: Zinv = Z^(p-2) by square-and-multiply, then x = X*Zinv, y = Y*Zinv.
// Data-independent sequence of DATA_WIDTH squarings plus one multiply per set exponent bit; start ignored while busy or during done.
module point_to_affine
  import parameters_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  point_to_affine_if.slave bus
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SQ   = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_xl;
  logic [DATA_WIDTH-1:0] r_yl;
  logic [DATA_WIDTH-1:0] r_zl;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_y;
  logic [IDX_W-1:0]      r_i;
  logic                  r_z_zero;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_m1_start;
  logic                  r_m2_start;
  logic                  r_m1_pend;
  logic                  r_m2_pend;
  logic                  r_got1;
  logic                  r_got2;

  logic [DATA_WIDTH-1:0] w_m1_a;
  logic [DATA_WIDTH-1:0] w_m1_b;
  logic [DATA_WIDTH-1:0] w_m1_res;
  logic [DATA_WIDTH-1:0] w_m2_res;
  logic                  w_m1_done;
  logic                  w_m2_done;
  logic                  w_m1_ok;
  logic                  w_m2_ok;

  always_comb begin
    w_m1_a = r_acc;
    w_m1_b = r_acc;
    case (r_state)
      S_MUL:   w_m1_b = r_zl;
      S_FIN:   w_m1_a = r_xl;
      default: ;
    endcase
  end

  mul_mont mul1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (r_m1_start),
    .i_a     (w_m1_a),
    .i_b     (w_m1_b),
    .o_done  (w_m1_done),
    .o_res   (w_m1_res)
  );

  mul_mont mul2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (r_m2_start),
    .i_a     (r_yl),
    .i_b     (r_acc),
    .o_done  (w_m2_done),
    .o_res   (w_m2_res)
  );

  // A done only counts once its start pulse has dropped.
  assign w_m1_ok = r_m1_pend & ~r_m1_start & w_m1_done;
  assign w_m2_ok = r_m2_pend & ~r_m2_start & w_m2_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_xl       <= '0;
      r_yl       <= '0;
      r_zl       <= '0;
      r_acc      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_i        <= '0;
      r_z_zero   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_m1_start <= 1'b0;
      r_m2_start <= 1'b0;
      r_m1_pend  <= 1'b0;
      r_m2_pend  <= 1'b0;
      r_got1     <= 1'b0;
      r_got2     <= 1'b0;
    end else begin
      r_m1_start <= 1'b0;
      r_m2_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !r_done) begin
            r_xl      <= bus.X;
            r_yl      <= bus.Y;
            r_zl      <= bus.Z;
            r_acc     <= MONT_ONE;
            r_i       <= IDX_W'(DATA_WIDTH - 1);
            r_busy    <= 1'b1;
            r_m1_pend <= 1'b0;
            r_state   <= S_SQ;
          end
        end
        S_SQ: begin
          if (!r_m1_pend) begin
            r_m1_start <= 1'b1;
            r_m1_pend  <= 1'b1;
          end else if (w_m1_ok) begin
            r_acc     <= w_m1_res;
            r_m1_pend <= 1'b0;
            if (INV_EXP[r_i])
              r_state <= S_MUL;
            else if (r_i == '0)
              r_state <= S_FIN;
            else
              r_i <= r_i - IDX_W'(1);
          end
        end
        S_MUL: begin
          if (!r_m1_pend) begin
            r_m1_start <= 1'b1;
            r_m1_pend  <= 1'b1;
          end else if (w_m1_ok) begin
            r_acc     <= w_m1_res;
            r_m1_pend <= 1'b0;
            if (r_i == '0) begin
              r_state <= S_FIN;
            end else begin
              r_i     <= r_i - IDX_W'(1);
              r_state <= S_SQ;
            end
          end
        end
        S_FIN: begin
          if (!r_m1_pend && !r_m2_pend && !r_got1 && !r_got2) begin
            r_m1_start <= 1'b1;
            r_m2_start <= 1'b1;
            r_m1_pend  <= 1'b1;
            r_m2_pend  <= 1'b1;
          end else if (r_got1 && r_got2) begin
            r_got1  <= 1'b0;
            r_got2  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            if (w_m1_ok) begin
              r_got1    <= 1'b1;
              r_m1_pend <= 1'b0;
            end
            if (w_m2_ok) begin
              r_got2    <= 1'b1;
              r_m2_pend <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_x      <= w_m1_res;
          r_y      <= w_m2_res;
          r_z_zero <= (r_zl == '0);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.z_zero = r_z_zero;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_point_to_affine.sv
// Directed bench for point_to_affine; Montgomery values M(v) = 38*v mod p since R = 2^256.
module tb_point_to_affine;
  import parameters_pkg::*;

  localparam int MAXC = 20000;
  localparam logic [DATA_WIDTH-1:0] P   = {{(DATA_WIDTH-8){1'b1}}, 8'hED};
  localparam logic [DATA_WIDTH-1:0] M1  = 255'd38;
  localparam logic [DATA_WIDTH-1:0] M2  = 255'd76;
  localparam logic [DATA_WIDTH-1:0] M3  = 255'd114;
  localparam logic [DATA_WIDTH-1:0] M4  = 255'd152;
  localparam logic [DATA_WIDTH-1:0] M5  = 255'd190;
  localparam logic [DATA_WIDTH-1:0] M6  = 255'd228;
  localparam logic [DATA_WIDTH-1:0] M7  = 255'd266;
  localparam logic [DATA_WIDTH-1:0] M9  = 255'd342;
  localparam logic [DATA_WIDTH-1:0] MPM1 = P - 255'd38;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  point_to_affine_if bus_if ();

  point_to_affine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs, input logic [DATA_WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [DATA_WIDTH-1:0] xv, input logic [DATA_WIDTH-1:0] yv,
                      input logic [DATA_WIDTH-1:0] zv);
    bus_if.X     = xv;
    bus_if.Y     = yv;
    bus_if.Z     = zv;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      if (bus_if.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 255'(ok), 255'd1);
  endtask

  initial begin
    int ndone;
    logic seen;
    bus_if.start = 1'b0;
    bus_if.X = '0;
    bus_if.Y = '0;
    bus_if.Z = '0;
    repeat (3) @(negedge clk);
    check("rst_x", bus_if.x, '0);
    check("rst_y", bus_if.y, '0);
    check("rst_zz", 255'(bus_if.z_zero), '0);
    check("rst_busy", 255'(bus_if.busy), '0);
    check("rst_done", 255'(bus_if.done), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity Z
    kick(M5, M7, M1);
    check("a_busy", 255'(bus_if.busy), 255'd1);
    wait_done("a_done");
    check("a_x", bus_if.x, M5);
    check("a_y", bus_if.y, M7);
    check("a_zz", 255'(bus_if.z_zero), '0);
    @(negedge clk);
    check("a_done_pulse", 255'(bus_if.done), '0);
    check("a_busy_after", 255'(bus_if.busy), '0);
    check("a_x_held", bus_if.x, M5);

    // Z = 2; inputs change after start and must be ignored
    kick(M4, M6, M2);
    bus_if.X = M9;
    bus_if.Y = M9;
    bus_if.Z = M9;
    wait_done("b_done");
    check("b_x", bus_if.x, M2);
    check("b_y", bus_if.y, M3);
    check("b_zz", 255'(bus_if.z_zero), '0);
    @(negedge clk);

    // Z = 0
    kick(M9, M7, '0);
    wait_done("c_done");
    check("c_x", bus_if.x, '0);
    check("c_y", bus_if.y, '0);
    check("c_zz", 255'(bus_if.z_zero), 255'd1);
    @(negedge clk);

    // Second start mid-exponentiation, then a start coincident with done
    kick(M5, M7, M1);
    repeat (300) @(negedge clk);
    kick(M4, M6, M2);
    wait_done("d_done");
    check("d_x", bus_if.x, M5);
    check("d_y", bus_if.y, M7);
    bus_if.X = M9;
    bus_if.Y = M9;
    bus_if.Z = '0;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("d_start_on_done_busy", 255'(bus_if.busy), '0);
    ndone = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus_if.done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("d_extra_done", 255'(ndone), '0);
    check("d_x_held", bus_if.x, M5);

    // Reset during FIN
    kick(M4, M6, M2);
    seen = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      if (dut.r_state === 3'd3) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("e_reach_fin", 255'(seen), 255'd1);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_x", bus_if.x, '0);
    check("e_rst_y", bus_if.y, '0);
    check("e_rst_busy", 255'(bus_if.busy), '0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) ndone++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) ndone++;
    end
    check("e_no_done", 255'(ndone), '0);
    kick(M4, M6, M2);
    wait_done("e_done");
    check("e_x", bus_if.x, M2);
    check("e_y", bus_if.y, M3);

    // Back-to-back start in the cycle after done
    @(negedge clk);
    kick(M1, M1, MPM1);
    check("f_busy", 255'(bus_if.busy), 255'd1);
    wait_done("f_done");
    check("f_x", bus_if.x, MPM1);
    check("f_y", bus_if.y, MPM1);
    check("f_zz", 255'(bus_if.z_zero), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/point_to_affine.md
POINT_TO_AFFINE -- requirements
Module: point_to_affine

Interface
REQ-001 clk  input  1  rising-edge clock; the only clock in the block.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle request pulse; sampled only in IDLE.
REQ-004 X, Y, Z  input  DATA_WIDTH each  projective point in Montgomery form, same format point_double emits.
REQ-005 x, y  output  DATA_WIDTH each  affine coordinates in Montgomery form.
REQ-006 z_zero  output  1  set when the latched Z equals 0; valid with done.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse; x, y and z_zero are valid in that cycle and held afterwards.

Function
REQ-009 Computes Zinv = Z^(MODULUS-2) mod MODULUS by left-to-right square-and-multiply, then x = X*Zinv and y = Y*Zinv, all with mul_mont.
REQ-010 On an accepted start, X, Y and Z are latched into internal registers; later input changes are ignored until the next start.
REQ-011 States:
- IDLE
- SQ (acc = acc*acc)
- MUL (acc = acc*Zl)
- FIN (X*acc and Y*acc in parallel)
- DONE
REQ-012 IDLE->SQ on start: acc = MONT_ONE, bit index i = DATA_WIDTH-1.
REQ-013 SQ, on mul done: if INV_EXP[i]=1 go to MUL; otherwise, if i=0 go to FIN, else decrement i and start the next SQ.
REQ-014 MUL, on mul done: if i=0 go to FIN, else decrement i and go to SQ.
REQ-015 FIN starts both multipliers in the same cycle and waits until both dones have been seen; each done is latched independently.
REQ-016 DONE registers x, y and z_zero, pulses done for one cycle, then returns to IDLE.
REQ-017 Every multiplier start is a single-cycle pulse; a multiplier done is only honoured in a cycle after its start was deasserted.
REQ-018 All DATA_WIDTH exponent bits are processed with no leading-zero skip; latency is therefore data-independent apart from the variable latency of mul_mont.
REQ-019 Z = 0: the flow runs unchanged, giving x = y = 0, and z_zero = 1 at done.
REQ-020 start while busy is ignored, with no effect on state or outputs.
REQ-021 start in the same cycle as done is ignored; a new start is accepted from the cycle after done.

Reset
REQ-022 rst_n low, asynchronously and at any point in a computation: state = IDLE, and x, y, z_zero, busy, done, acc, i and all multiplier starts = 0.
REQ-023 The first start after rst_n deasserts performs a full, correct computation.

Structure
REQ-024 parameters_pkg holds DATA_WIDTH, MODULUS, MONT_ONE (R mod MODULUS) and INV_EXP (MODULUS-2).
REQ-025 The state enum is local to the module.
REQ-026 The block contains exactly two mul_mont instances:
- mul1: exponentiation, then X*acc.
- mul2: Y*acc only.
REQ-027 The block contains no adder or subtractor instances; the bit counter is $clog2(DATA_WIDTH) bits wide.

Verification (DATA_WIDTH = 255, MODULUS = 2^255-19; M(v) = v*R mod MODULUS)
REQ-028 Input X = M(5), Y = M(7), Z = MONT_ONE -> x = M(5), y = M(7), z_zero = 0, done high for exactly one cycle.
REQ-029 Input X = M(4), Y = M(6), Z = M(2) -> x = M(2), y = M(3).
REQ-030 Input Z = 0, X = M(9) -> x = 0, y = 0, z_zero = 1.
REQ-031 Second start at mid-exponentiation with different inputs -> the result matches the first inputs only, and exactly one done is produced.
REQ-032 rst_n pulsed low mid-FIN -> outputs go to 0 immediately with no done; a following start with REQ-029 inputs gives x = M(2), y = M(3).
REQ-033 Back-to-back operation: start in the cycle after done, with X = M(1), Y = M(1), Z = M(MODULUS-1) -> x = y = M(MODULUS-1).
